// File: rtl/change_dispenser_if.sv
// Change dispenser request/result bundle; master drives the request, slave returns pulses and totals.
// No backpressure: start is a level request sampled only when the dispenser is idle.
interface change_dispenser_if;
    logic       start;
    logic [9:0] paid;
    logic [9:0] price;
    logic       busy;
    logic       coin_q;
    logic       coin_d;
    logic       coin_n;
    logic       done;
    logic       insufficient;
    logic [9:0] change_total;
    logic [9:0] remaining;

    modport master (
        output start, paid, price,
        input  busy, coin_q, coin_d, coin_n, done, insufficient, change_total, remaining
    );

    modport slave (
        input  start, paid, price,
        output busy, coin_q, coin_d, coin_n, done, insufficient, change_total, remaining
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy 25/10/5 change dispenser; CALC one cycle after start, then one coin pulse per DISP with GAP_CYCLES idle between.
// No backpressure: start is ignored while busy; all pulses are registered Moore outputs.
module change_dispenser #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    change_dispenser_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, CALC, DISP, GAP, DONE, FAIL} state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t     state_q;
    logic [9:0] paid_q;
    logic [9:0] price_q;
    logic [9:0] change_total_q;
    logic [9:0] remaining_q;
    logic [2:0] coins_q;
    logic       done_q;
    logic       insuff_q;
    logic [3:0] gap_cnt_q;

    logic [9:0] diff_d;
    logic [9:0] step_d;
    logic [9:0] rem_after_d;

    function automatic logic [2:0] pick_coin(input logic [9:0] amt);
        if (amt >= 10'd25) return 3'b100;
        if (amt >= 10'd10) return 3'b010;
        return 3'b001;
    endfunction

    // Only consumed in CALC when paid_q >= price_q, so the difference never wraps.
    always_comb begin
        diff_d      = paid_q - price_q;
        step_d      = coins_q[2] ? 10'd25 : (coins_q[1] ? 10'd10 : 10'd5);
        rem_after_d = remaining_q - step_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            paid_q         <= '0;
            price_q        <= '0;
            change_total_q <= '0;
            remaining_q    <= '0;
            coins_q        <= '0;
            done_q         <= 1'b0;
            insuff_q       <= 1'b0;
            gap_cnt_q      <= '0;
        end else begin
            coins_q  <= '0;
            done_q   <= 1'b0;
            insuff_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        paid_q  <= bus.paid;
                        price_q <= bus.price;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (paid_q < price_q) begin
                        insuff_q <= 1'b1;
                        state_q  <= FAIL;
                    end else begin
                        change_total_q <= diff_d;
                        remaining_q    <= diff_d;
                        if (diff_d >= 10'd5) begin
                            coins_q <= pick_coin(diff_d);
                            state_q <= DISP;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DISP: begin
                    remaining_q <= rem_after_d;
                    if (rem_after_d < 10'd5) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (GAP_CYCLES == 0) begin
                        coins_q <= pick_coin(rem_after_d);
                        state_q <= DISP;
                    end else begin
                        gap_cnt_q <= GAP_LAST;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == 4'd0) begin
                        coins_q <= pick_coin(remaining_q);
                        state_q <= DISP;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                FAIL:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.coin_q       = coins_q[2];
    assign bus.coin_d       = coins_q[1];
    assign bus.coin_n       = coins_q[0];
    assign bus.done         = done_q;
    assign bus.insufficient = insuff_q;
    assign bus.change_total = change_total_q;
    assign bus.remaining    = remaining_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: instance 0 uses GAP_CYCLES=1, instance 1 uses GAP_CYCLES=0.
// Expected per-cycle pulses come from a greedy-change model; outputs sampled 1ns after each rising edge.
module tb_change_dispenser;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    change_dispenser_if if0 ();
    change_dispenser_if if1 ();

    change_dispenser #(.GAP_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    change_dispenser #(.GAP_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    int total = 0;
    int bad   = 0;

    // Vector layout: {busy, coin_q, coin_d, coin_n, done, insufficient}
    logic [5:0] exp_q[$];
    logic [9:0] ct_m[2];
    logic [9:0] rem_m[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input logic s, input logic [9:0] pd, input logic [9:0] pr);
        if (idx == 0) begin
            if0.start = s; if0.paid = pd; if0.price = pr;
        end else begin
            if1.start = s; if1.paid = pd; if1.price = pr;
        end
    endtask

    function automatic logic [5:0] vec_of(input int idx);
        if (idx == 0)
            return {if0.busy, if0.coin_q, if0.coin_d, if0.coin_n, if0.done, if0.insufficient};
        return {if1.busy, if1.coin_q, if1.coin_d, if1.coin_n, if1.done, if1.insufficient};
    endfunction

    function automatic logic [9:0] ct_of(input int idx);
        return (idx == 0) ? if0.change_total : if1.change_total;
    endfunction

    function automatic logic [9:0] rem_of(input int idx);
        return (idx == 0) ? if0.remaining : if1.remaining;
    endfunction

    // Greedy change: one CALC cycle, then coins largest-first with gap idles between, then done.
    task automatic model(input int idx, input int pd, input int pr);
        int gap;
        int amt;
        gap = (idx == 0) ? 1 : 0;
        exp_q.push_back(6'b100000);
        if (pd < pr) begin
            exp_q.push_back(6'b100001);
        end else begin
            amt = pd - pr;
            ct_m[idx] = 10'(amt);
            while (amt >= 5) begin
                if (amt >= 25) begin
                    exp_q.push_back(6'b110000); amt -= 25;
                end else if (amt >= 10) begin
                    exp_q.push_back(6'b101000); amt -= 10;
                end else begin
                    exp_q.push_back(6'b100100); amt -= 5;
                end
                if (amt >= 5)
                    for (int g = 0; g < gap; g++) exp_q.push_back(6'b100000);
            end
            exp_q.push_back(6'b100010);
            rem_m[idx] = 10'(amt);
        end
    endtask

    task automatic run(input int idx, input int pd, input int pr, input bit hold, input bit perturb);
        int other;
        int launches;
        logic [9:0] np;
        logic [9:0] nr;
        other    = 1 - idx;
        launches = 1;
        chk("idle_before", 32'(vec_of(idx)), 32'd0);
        drive(idx, 1'b1, 10'(pd), 10'(pr));
        model(idx, pd, pr);
        while (1) begin
            tick;
            chk("other_idle", 32'(vec_of(other)), 32'd0);
            if (exp_q.size() != 0) begin
                chk("seq", 32'(vec_of(idx)), 32'(exp_q.pop_front()));
                np = perturb ? 10'($urandom_range(0, 1023)) : 10'(pd);
                nr = perturb ? 10'($urandom_range(0, 1023)) : 10'(pr);
                drive(idx, hold, np, nr);
            end else begin
                chk("idle_after", 32'(vec_of(idx)), 32'd0);
                chk("change_total", 32'(ct_of(idx)), 32'(ct_m[idx]));
                chk("remaining", 32'(rem_of(idx)), 32'(rem_m[idx]));
                if (hold && launches == 1) begin
                    np = 10'($urandom_range(0, 1023));
                    nr = 10'($urandom_range(0, 400));
                    drive(idx, 1'b1, np, nr);
                    model(idx, int'(np), int'(nr));
                    launches++;
                end else begin
                    drive(idx, 1'b0, 10'd0, 10'd0);
                    break;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 10'd0, 10'd0);
        drive(1, 1'b0, 10'd0, 10'd0);
        tick;
        tick;
        for (int i = 0; i < 2; i++) begin
            chk("reset_vec", 32'(vec_of(i)), 32'd0);
            chk("reset_ct", 32'(ct_of(i)), 32'd0);
            chk("reset_rem", 32'(rem_of(i)), 32'd0);
            ct_m[i]  = '0;
            rem_m[i] = '0;
        end
        rst = 1'b0;
        tick;

        run(0, 100, 65, 1'b0, 1'b0);
        run(0, 50, 75, 1'b0, 1'b0);
        run(0, 75, 75, 1'b0, 1'b0);
        run(1, 103, 0, 1'b0, 1'b0);

        // Reset in the first GAP of 100/65 aborts the sequence.
        chk("pre_rst_idle", 32'(vec_of(0)), 32'd0);
        drive(0, 1'b1, 10'd100, 10'd65);
        tick;
        drive(0, 1'b0, 10'd100, 10'd65);
        chk("rst_calc", 32'(vec_of(0)), 32'h20);
        tick;
        chk("rst_coin_q", 32'(vec_of(0)), 32'h30);
        tick;
        chk("rst_gap", 32'(vec_of(0)), 32'h20);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_vec", 32'(vec_of(0)), 32'd0);
        chk("rst_ct", 32'(ct_of(0)), 32'd0);
        chk("rst_rem", 32'(rem_of(0)), 32'd0);
        chk("rst_ct_other", 32'(ct_of(1)), 32'd0);
        ct_m[0] = '0; rem_m[0] = '0; ct_m[1] = '0; rem_m[1] = '0;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("rst_no_coins", 32'(vec_of(0)), 32'd0);
        end

        // Reset wins over start in the same cycle.
        rst = 1'b1;
        drive(0, 1'b1, 10'd100, 10'd65);
        tick;
        rst = 1'b0;
        drive(0, 1'b0, 10'd0, 10'd0);
        chk("rst_prio_a", 32'(vec_of(0)), 32'd0);
        tick;
        chk("rst_prio_b", 32'(vec_of(0)), 32'd0);

        run(0, 100, 65, 1'b0, 1'b0);
        run(0, 100, 65, 1'b1, 1'b1);
        run(1, 100, 65, 1'b1, 1'b1);

        for (int n = 0; n < 16; n++) begin
            run(int'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 600)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter: GAP_CYCLES, default 1, number of idle cycles inserted between consecutive coin pulses (0..15).
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to compute and dispense change; sampled only in IDLE.
REQ-005 Port: paid  input  10  amount paid in cents, unsigned; driven by the register file amount-paid readout.
REQ-006 Port: price  input  10  selected item price in cents, unsigned.
REQ-007 Port: busy  output  1  high in every state except IDLE.
REQ-008 Port: coin_q / coin_d / coin_n  output  1 each  one-cycle pulses releasing a 25c / 10c / 5c coin.
REQ-009 Port: done  output  1  one-cycle pulse: dispense sequence finished.
REQ-010 Port: insufficient  output  1  one-cycle pulse: paid < price, nothing dispensed.
REQ-011 Port: change_total  output  10  paid - price latched in CALC; held until next CALC or reset.
REQ-012 Port: remaining  output  10  change not yet dispensed; after done it holds the undispensable residue (0..4).

Function
REQ-013 The block SHALL implement the states IDLE, CALC, DISP, GAP, DONE, FAIL.
REQ-014 IDLE with start=1 SHALL latch paid and price and go to CALC; start in any other state SHALL be ignored.
REQ-015 CALC (exactly one cycle): paid < price -> FAIL; else change_total and remaining <= paid - price, then DISP if paid - price >= 5, else DONE.
REQ-016 Comparison and subtraction SHALL be 10-bit unsigned; the subtraction is performed only when paid >= price, so no wrap occurs.
REQ-017 DISP (one cycle) SHALL assert exactly one coin output, chosen from remaining at state entry: coin_q if >= 25, else coin_d if >= 10, else coin_n.
REQ-018 At the end of DISP, remaining SHALL be reduced by 25, 10 or 5, matching the asserted coin.
REQ-019 After DISP: if the new remaining < 5 -> DONE; else GAP_CYCLES = 0 -> DISP, otherwise GAP.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles, with all coin outputs low, then return to DISP.
REQ-021 DONE SHALL assert done for one cycle; FAIL SHALL assert insufficient for one cycle; both SHALL then return to IDLE.
REQ-022 Coin, done and insufficient outputs SHALL decode from registered state only (Moore); they never depend combinationally on start, paid or price.
REQ-023 At most one of coin_q, coin_d, coin_n, done, insufficient SHALL be high in any cycle.
REQ-024 Changes on paid or price after the start cycle SHALL NOT affect the sequence in progress.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE on the next cycle from any state, including mid-DISP or mid-GAP.
REQ-026 Reset values: busy=0, coin_q=coin_d=coin_n=0, done=0, insufficient=0, change_total=0, remaining=0, GAP counter=0.
REQ-027 Reset SHALL take priority over start in the same cycle.

Verification
REQ-028 GAP_CYCLES=1; paid=100, price=65, start at cycle 0 -> CALC c1 (change_total=35), coin_q c2, GAP c3, coin_d c4, done c5, remaining=0, busy low from c6.
REQ-029 paid=50, price=75, start -> insufficient pulse in cycle 2, no coin pulses, change_total unchanged, busy low in cycle 3.
REQ-030 paid=75, price=75, start -> done pulse in cycle 2, no coin pulses, change_total=0, remaining=0.
REQ-031 GAP_CYCLES=0; paid=103, price=0 -> four consecutive coin_q pulses (cycles 2-5), done in cycle 6, remaining=3.
REQ-032 rst asserted during the first GAP of the 100/65 case -> next cycle IDLE, all outputs 0, no further coins; a new start then runs normally.
REQ-033 start held high for the whole 100/65 sequence -> exactly one sequence per pass through IDLE; paid/price changed mid-sequence -> no effect on coins.
